// File: rtl/pipo_load_arbiter_if.sv
// Bus bundle for pipo_load_arbiter: requester side (req/d_in) and shared-register side.
// Optional macro PIPO_ARB_LOCK_EN adds the per-requester lock lines.
interface pipo_load_arbiter_if #(
  parameter int N = 4
);
  logic [3:0]     req;
  logic [4*N-1:0] d_in;
  logic [3:0]     gnt;
  logic [N-1:0]   q_out;
  logic [1:0]     owner;
  logic           q_valid;
  logic [7:0]     load_cnt;
`ifdef PIPO_ARB_LOCK_EN
  logic [3:0]     lock;
`endif

  // Requester/environment side drives requests and observes the shared register.
  modport master (
`ifdef PIPO_ARB_LOCK_EN
    output lock,
`endif
    output req, d_in,
    input  gnt, q_out, owner, q_valid, load_cnt
  );

  // Arbiter side.
  modport slave (
`ifdef PIPO_ARB_LOCK_EN
    input  lock,
`endif
    input  req, d_in,
    output gnt, q_out, owner, q_valid, load_cnt
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter loading one of four requester slots into a shared N-bit register.
// Optional macro PIPO_ARB_LOCK_EN enables lock-based ownership hold (max 4 locked re-grants).
module pipo_load_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset_al_in,
  pipo_load_arbiter_if.slave   bus
);

  logic [N-1:0] q_out_r;
  logic [1:0]   owner_r;
  logic [3:0]   gnt_r;
  logic         q_valid_r;
  logic [7:0]   load_cnt_r;
  logic [1:0]   ptr_r;
`ifdef PIPO_ARB_LOCK_EN
  logic [2:0]   run_r;
`endif

  logic         any_req_s;
  logic [1:0]   rr_win_s;
  logic         rr_found_s;
  logic         lock_take_s;
  logic [1:0]   win_s;
  logic [N-1:0] slot_s;
  logic [3:0]   gnt_onehot_s;

  assign any_req_s = |bus.req;

  // Round-robin search starting one past the last winner.
  always_comb begin
    rr_win_s   = ptr_r;
    rr_found_s = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!rr_found_s && bus.req[ptr_r + 2'(i)]) begin
        rr_win_s   = ptr_r + 2'(i);
        rr_found_s = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Lock override: previous winner keeps the register while run budget remains.
`ifdef PIPO_ARB_LOCK_EN
  always_comb begin
    if (q_valid_r && bus.req[ptr_r] && bus.lock[ptr_r] && (run_r < 3'd4)) begin
      lock_take_s = 1'b1;
    end else begin
      lock_take_s = 1'b0;
    end
  end
`else
  assign lock_take_s = 1'b0;
`endif

  // Final winner, its data slot and one-hot grant.
  always_comb begin
    if (lock_take_s) begin
      win_s = ptr_r;
    end else begin
      win_s = rr_win_s;
    end
    case (win_s)
      2'd0:    slot_s = bus.d_in[0*N +: N];
      2'd1:    slot_s = bus.d_in[1*N +: N];
      2'd2:    slot_s = bus.d_in[2*N +: N];
      2'd3:    slot_s = bus.d_in[3*N +: N];
      default: slot_s = {N{1'b0}};
    endcase
    case (win_s)
      2'd0:    gnt_onehot_s = 4'b0001;
      2'd1:    gnt_onehot_s = 4'b0010;
      2'd2:    gnt_onehot_s = 4'b0100;
      2'd3:    gnt_onehot_s = 4'b1000;
      default: gnt_onehot_s = 4'b0000;
    endcase
  end

  // Shared register, ownership, grant pulse, pointer and saturating load counter.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      q_out_r    <= {N{1'b0}};
      owner_r    <= 2'd0;
      gnt_r      <= 4'b0000;
      q_valid_r  <= 1'b0;
      load_cnt_r <= 8'd0;
      ptr_r      <= 2'd3;
    end else if (any_req_s) begin
      q_out_r    <= slot_s;
      owner_r    <= win_s;
      gnt_r      <= gnt_onehot_s;
      q_valid_r  <= 1'b1;
      ptr_r      <= win_s;
      if (load_cnt_r != 8'hFF) begin
        load_cnt_r <= load_cnt_r + 8'd1;
      end else begin
        load_cnt_r <= load_cnt_r;
      end
    end else begin
      gnt_r      <= 4'b0000;
    end
  end

`ifdef PIPO_ARB_LOCK_EN
  // Consecutive locked re-grant counter; any rotation grant or idle edge clears it.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      run_r <= 3'd0;
    end else if (any_req_s && lock_take_s) begin
      run_r <= run_r + 3'd1;
    end else begin
      run_r <= 3'd0;
    end
  end
`endif

  assign bus.q_out    = q_out_r;
  assign bus.owner    = owner_r;
  assign bus.gnt      = gnt_r;
  assign bus.q_valid  = q_valid_r;
  assign bus.load_cnt = load_cnt_r;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter (N=4); lock scenario runs only with PIPO_ARB_LOCK_EN.
module tb_pipo_load_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n_s;
  int   checks_cnt;
  int   errors_cnt;

  pipo_load_arbiter_if #(.N(N)) bus ();

  pipo_load_arbiter #(.N(N)) dut (
    .clk         (clk),
    .reset_al_in (rst_n_s),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n_s = 1'b0;
    #1;
    rst_n_s = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_own [8];
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n_s    = 1'b0;
    bus.req    = 4'b0000;
    bus.d_in   = 16'h0000;
`ifdef PIPO_ARB_LOCK_EN
    bus.lock   = 4'b0000;
`endif
    #1;
    check_eq("rst_q_out", 32'(bus.q_out), 32'h0);
    check_eq("rst_owner", 32'(bus.owner), 32'h0);
    check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
    check_eq("rst_q_valid", 32'(bus.q_valid), 32'h0);
    check_eq("rst_load_cnt", 32'(bus.load_cnt), 32'h0);
    #1;
    rst_n_s = 1'b1;

    // First load after reset: requester 0 has priority.
    bus.req  = 4'b0001;
    bus.d_in = 16'h000A;
    step();
    check_eq("first_q_out", 32'(bus.q_out), 32'hA);
    check_eq("first_owner", 32'(bus.owner), 32'h0);
    check_eq("first_gnt", 32'(bus.gnt), 32'h1);
    check_eq("first_q_valid", 32'(bus.q_valid), 32'h1);
    check_eq("first_load_cnt", 32'(bus.load_cnt), 32'h1);

    // All four requesting: strict rotation 0,1,2,3,0,...
    do_reset();
    bus.req  = 4'b1111;
    bus.d_in = 16'h4321;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rr_owner", 32'(bus.owner), 32'(i % 4));
      check_eq("rr_q_out", 32'(bus.q_out), 32'((i % 4) + 1));
      check_eq("rr_gnt", 32'(bus.gnt), 32'(1 << (i % 4)));
    end
    check_eq("rr_load_cnt", 32'(bus.load_cnt), 32'd8);

    // Load 5 then idle three edges: everything holds, grant drops.
    bus.req  = 4'b0001;
    bus.d_in = 16'h0005;
    step();
    check_eq("pre_idle_q_out", 32'(bus.q_out), 32'h5);
    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("idle_q_out", 32'(bus.q_out), 32'h5);
      check_eq("idle_gnt", 32'(bus.gnt), 32'h0);
      check_eq("idle_load_cnt", 32'(bus.load_cnt), 32'd9);
      check_eq("idle_q_valid", 32'(bus.q_valid), 32'h1);
    end

    // Single persistent requester gets back-to-back grants.
    bus.req  = 4'b0100;
    bus.d_in = 16'h0900;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("b2b_gnt", 32'(bus.gnt), 32'h4);
      check_eq("b2b_owner", 32'(bus.owner), 32'h2);
      check_eq("b2b_q_out", 32'(bus.q_out), 32'h9);
    end
    check_eq("b2b_load_cnt", 32'(bus.load_cnt), 32'd11);

    // Request pulsed between edges is not seen.
    bus.req = 4'b1000;
    #2;
    bus.req = 4'b0000;
    step();
    check_eq("glitch_gnt", 32'(bus.gnt), 32'h0);
    check_eq("glitch_load_cnt", 32'(bus.load_cnt), 32'd11);

    // Async reset mid-sequence while holding 7, then restart from ptr=3.
    bus.req  = 4'b0001;
    bus.d_in = 16'h0007;
    step();
    check_eq("pre_rst_q_out", 32'(bus.q_out), 32'h7);
    rst_n_s = 1'b0;
    #1;
    check_eq("mid_rst_q_out", 32'(bus.q_out), 32'h0);
    check_eq("mid_rst_owner", 32'(bus.owner), 32'h0);
    check_eq("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check_eq("mid_rst_q_valid", 32'(bus.q_valid), 32'h0);
    check_eq("mid_rst_load_cnt", 32'(bus.load_cnt), 32'h0);
    rst_n_s  = 1'b1;
    bus.req  = 4'b1010;
    bus.d_in = 16'hB0C0;
    exp_own[0] = 2'd1;
    exp_own[1] = 2'd3;
    exp_own[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("post_rst_owner", 32'(bus.owner), 32'(exp_own[i]));
      check_eq("post_rst_q_out", 32'(bus.q_out), (exp_own[i] == 2'd1) ? 32'hC : 32'hB);
    end
    check_eq("post_rst_load_cnt", 32'(bus.load_cnt), 32'd3);

    // Load counter saturates at 255.
    do_reset();
    bus.req  = 4'b0001;
    bus.d_in = 16'h0001;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) check_eq("cnt_254", 32'(bus.load_cnt), 32'd254);
      if (i == 254) check_eq("cnt_255", 32'(bus.load_cnt), 32'd255);
    end
    check_eq("cnt_sat", 32'(bus.load_cnt), 32'd255);
    step();
    check_eq("cnt_sat_hold", 32'(bus.load_cnt), 32'd255);

`ifdef PIPO_ARB_LOCK_EN
    // Locked requester 0: initial grant plus 4 re-grants, then forced rotation.
    do_reset();
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    bus.d_in = 16'h0021;
    exp_own = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("lock_owner", 32'(bus.owner), 32'(exp_own[i]));
    end
    bus.lock = 4'b0000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
